// File: rtl/fft_mag_engine.sv
// Per-bin magnitude engine for one FFT frame.
// One shared two-stage pipeline, exact-square or alpha-max-beta-min mode.
module fft_mag_engine #(
  parameter int N_BINS   = 4,
  parameter int IN_W     = 16,
  parameter int MAG_W    = 16,
  parameter int SQ_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_BINS*IN_W-1:0]    in_re,
  input  logic [N_BINS*IN_W-1:0]    in_im,
  input  logic                      in_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N_BINS*MAG_W-1:0]   out_mag,
  output logic [((N_BINS > 1) ? $clog2(N_BINS) : 1)-1:0] out_peak_idx,
  output logic [MAG_W-1:0]          out_peak_mag,
  output logic                      out_sat,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int IW = (N_BINS > 1) ? $clog2(N_BINS) : 1;
  localparam int CW = $clog2(N_BINS + 2);
  localparam int PW = 2 * IN_W;
  localparam int WW = ((PW > MAG_W) ? PW : MAG_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, nxt;

  logic [N_BINS*IN_W-1:0] lat_re, lat_im;
  logic                   lat_mode;
  logic [CW-1:0]          cnt;
  logic                   accept, issue;

  logic signed [IN_W-1:0] re_k, im_k;
  logic [IN_W-1:0]        are, aim, mx, mn;
  logic signed [PW-1:0]   sq_re, sq_im;

  logic                   s1_v, s1_mode;
  logic [IW-1:0]          s1_idx;
  logic [PW-1:0]          s1_a, s1_b;

  logic [PW-1:0]          sq_sum;
  logic [IN_W+1:0]        tri_mn;
  logic [IN_W:0]          approx;
  logic [WW-1:0]          wide;
  logic                   clip;

  logic                   s2_v, s2_sat;
  logic [IW-1:0]          s2_idx;
  logic [MAG_W-1:0]       s2_mag;

  assign accept    = (state == IDLE) && in_valid && in_ready;
  assign issue     = (state == RUN) && (cnt < CW'(N_BINS));
  assign out_valid = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = RUN;
      RUN:  if (cnt == CW'(N_BINS + 1)) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Registered ready: high only while sitting in IDLE
  always_ff @(posedge clk) begin
    if (rst) in_ready <= 1'b0;
    else     in_ready <= (nxt == IDLE);
  end

  // Frame capture and RUN cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_re   <= '0;
      lat_im   <= '0;
      lat_mode <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      lat_re   <= in_re;
      lat_im   <= in_im;
      lat_mode <= in_mode;
      cnt      <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Stage-1 operand select: squares, abs, max/min of the issued bin
  always_comb begin
    re_k = '0;
    im_k = '0;
    if (issue) begin
      re_k = lat_re[int'(cnt)*IN_W +: IN_W];
      im_k = lat_im[int'(cnt)*IN_W +: IN_W];
    end
    sq_re = PW'(re_k) * PW'(re_k);
    sq_im = PW'(im_k) * PW'(im_k);
    are   = re_k[IN_W-1] ? IN_W'(-re_k) : IN_W'(re_k);
    aim   = im_k[IN_W-1] ? IN_W'(-im_k) : IN_W'(im_k);
    mx    = (are >= aim) ? are : aim;
    mn    = (are >= aim) ? aim : are;
  end

  // Stage-1 pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_mode <= 1'b0;
      s1_idx  <= '0;
      s1_a    <= '0;
      s1_b    <= '0;
    end else begin
      s1_v    <= issue;
      s1_mode <= lat_mode;
      s1_idx  <= cnt[IW-1:0];
      s1_a    <= lat_mode ? PW'(mx) : PW'(sq_re);
      s1_b    <= lat_mode ? PW'(mn) : PW'(sq_im);
    end
  end

  // Stage-2 arithmetic: combine and saturate
  always_comb begin
    sq_sum = s1_a + s1_b;
    tri_mn = (IN_W+2)'(s1_b[IN_W-1:0]) * (IN_W+2)'(3);
    approx = (IN_W+1)'(s1_a[IN_W-1:0])
           + (IN_W+1)'(tri_mn >> 3);
    wide   = s1_mode ? WW'(approx) : WW'(sq_sum >> SQ_SHIFT);
    clip   = |(wide >> MAG_W);
  end

  // Stage-2 pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v   <= 1'b0;
      s2_sat <= 1'b0;
      s2_idx <= '0;
      s2_mag <= '0;
    end else begin
      s2_v   <= s1_v;
      s2_sat <= clip;
      s2_idx <= s1_idx;
      s2_mag <= clip ? '1 : wide[MAG_W-1:0];
    end
  end

  // Result slots, saturation flag and running peak (ties keep lower index)
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      out_mag      <= '0;
      out_sat      <= 1'b0;
      out_peak_idx <= '0;
      out_peak_mag <= '0;
    end else if (s2_v) begin
      out_mag[int'(s2_idx)*MAG_W +: MAG_W] <= s2_mag;
      out_sat <= out_sat | s2_sat;
      if (s2_mag > out_peak_mag) begin
        out_peak_mag <= s2_mag;
        out_peak_idx <= s2_idx;
      end
    end
  end

endmodule

// File: tb/tb_fft_mag_engine.sv
// Scoreboard bench for fft_mag_engine.
// Model computes magnitudes from the input bins with plain integer math.
module tb_fft_mag_engine;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int M  = 16;
  localparam int SQ = 0;

  typedef struct packed {
    logic [N*M-1:0] mag;
    logic [1:0]     idx;
    logic [M-1:0]   pk;
    logic           sat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_re, in_im;
  logic           in_mode, in_valid, in_ready;
  logic [N*M-1:0] out_mag;
  logic [1:0]     out_peak_idx;
  logic [M-1:0]   out_peak_mag;
  logic           out_sat, out_valid, out_ready;

  fft_mag_engine #(
    .N_BINS(N), .IN_W(W), .MAG_W(M), .SQ_SHIFT(SQ)
  ) dut (
    .clk(clk), .rst(rst),
    .in_re(in_re), .in_im(in_im),
    .in_mode(in_mode), .in_valid(in_valid),
    .in_ready(in_ready),
    .out_mag(out_mag), .out_peak_idx(out_peak_idx),
    .out_peak_mag(out_peak_mag), .out_sat(out_sat),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   hs_edge = 0;
  int   rdy_mode = 1;
  bit   gap_chk = 0;
  logic prev_v = 1'b0;
  exp_t sbq[$];
  int   cur_re[N], cur_im[N];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input int re[N], input int im[N],
                                 input logic mode);
    exp_t e;
    longint v, a, b, hi, lo;
    e = '0;
    for (int k = 0; k < N; k++) begin
      if (!mode) begin
        v = (longint'(re[k]) * re[k] + longint'(im[k]) * im[k]) >> SQ;
      end else begin
        a  = (re[k] < 0) ? -longint'(re[k]) : longint'(re[k]);
        b  = (im[k] < 0) ? -longint'(im[k]) : longint'(im[k]);
        hi = (a >= b) ? a : b;
        lo = (a >= b) ? b : a;
        v  = hi + (3 * lo) / 8;
      end
      if (v > 65535) begin
        v = 65535;
        e.sat = 1'b1;
      end
      e.mag[k*M +: M] = 16'(v);
      if (v > longint'(e.pk)) begin
        e.pk  = 16'(v);
        e.idx = 2'(k);
      end
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver: 0 hold, 1 always, else random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Accept monitor: push the model's answer for each accepted frame
  always @(negedge clk) begin
    int re[N], im[N];
    if (rst) begin
      sbq.delete();
    end else if (in_valid && in_ready) begin
      for (int k = 0; k < N; k++) begin
        re[k] = int'($signed(in_re[k*W +: W]));
        im[k] = int'($signed(in_im[k*W +: W]));
      end
      sbq.push_back(model(re, im, in_mode));
      acc_edge = cyc + 1;
      if (gap_chk) chk("accept_gap", 64'(acc_edge - hs_edge), 64'd1);
    end
  end

  // Output monitor: latency on rise, compare on handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=1 required=0");
        end else begin
          chk("latency", 64'(cyc - acc_edge), 64'(N + 2));
        end
      end
      if (out_valid && out_ready && sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("out_mag", 64'(out_mag), 64'(e.mag));
        chk("peak_idx", 64'(out_peak_idx), 64'(e.idx));
        chk("peak_mag", 64'(out_peak_mag), 64'(e.pk));
        chk("sat", 64'(out_sat), 64'(e.sat));
        hs_edge = cyc + 1;
      end
      prev_v = out_valid;
    end
  end

  task automatic drive(input logic mode);
    for (int k = 0; k < N; k++) begin
      in_re[k*W +: W] = 16'(cur_re[k]);
      in_im[k*W +: W] = 16'(cur_im[k]);
    end
    in_mode  = mode;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_re    = {$urandom, $urandom};
        in_im    = {$urandom, $urandom};
        in_mode  = 1'($urandom_range(0, 1));
        return;
      end
    end
    chk("accept_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (sbq.size() == 0 && !out_valid) return;
    end
    chk("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  task automatic set_bins(input int r0, i0, r1, i1, r2, i2, r3, i3);
    cur_re[0] = r0; cur_im[0] = i0;
    cur_re[1] = r1; cur_im[1] = i1;
    cur_re[2] = r2; cur_im[2] = i2;
    cur_re[3] = r3; cur_im[3] = i3;
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_mag"}, 64'(out_mag), 64'd0);
    chk({nm, "_pidx"}, 64'(out_peak_idx), 64'd0);
    chk({nm, "_pmag"}, 64'(out_peak_mag), 64'd0);
    chk({nm, "_sat"}, 64'(out_sat), 64'd0);
  endtask

  function automatic int rv();
    case ($urandom_range(0, 7))
      0: return -32768;
      1: return 32767;
      2: return 0;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    exp_t bp;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_re    = '0;
    in_im    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk_idle_zero("rst");
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // exact squared mode
    set_bins(3, 4, 0, 0, -5, 12, 1, -1);
    drive(1'b0);
    wait_accept();
    wait_drain();

    // saturation
    set_bins(200, 0, 256, 0, 0, -1, 0, 0);
    drive(1'b0);
    wait_accept();
    wait_drain();

    // approximate mode
    set_bins(100, -40, -32768, -32768, 0, 0, 7, 7);
    drive(1'b1);
    wait_accept();
    wait_drain();

    // tie plus backpressure with a second frame waiting
    rdy_mode = 0;
    @(posedge clk);
    #1;
    set_bins(0, 7, 0, 7, 0, 7, 0, 7);
    bp = model(cur_re, cur_im, 1'b0);
    drive(1'b0);
    wait_accept();
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    set_bins(3, 4, 0, 0, -5, 12, 1, -1);
    drive(1'b0);
    gap_chk = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_mag", 64'(out_mag), 64'(bp.mag));
      chk("bp_pidx", 64'(out_peak_idx), 64'(bp.idx));
    end
    rdy_mode = 1;
    wait_accept();
    gap_chk = 0;
    wait_drain();

    // reset two cycles after accept
    set_bins(3, 4, 0, 0, -5, 12, 1, -1);
    drive(1'b0);
    wait_accept();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle_zero("abort");
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("abort_in_ready_rise", 64'(in_ready), 64'd1);
    repeat (N + 4) @(posedge clk);
    #1;
    chk_idle_zero("abort_later");
    drive(1'b0);
    wait_accept();
    wait_drain();

    // randomized frames with random backpressure
    rdy_mode = 2;
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < N; k++) begin
        cur_re[k] = rv();
        cur_im[k] = rv();
      end
      drive(1'($urandom_range(0, 1)));
      wait_accept();
    end
    wait_drain();
    rdy_mode = 1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_mag_engine.md
Name: fft_mag_engine

Overview:
Parametrised successor to the fixed 4-bin magnitude stage. It accepts one frame of N_BINS complex FFT bins over a valid/ready handshake, then computes per-bin magnitude through a single shared 2-stage pipeline, one bin per cycle. Two modes are supported: exact squared magnitude and alpha-max-beta-min approximate magnitude. Results are saturated, the frame peak bin is tracked, and the frame is presented on an output handshake. The block sits between the FFT core and the spectral post-processing/peak-detect logic.

Parameters:
N_BINS, 4, bins per frame (>=2)
IN_W, 16, signed two's-complement width of each re/im input
MAG_W, 16, unsigned width of each output magnitude
SQ_SHIFT, 0, right shift applied to the squared sum in mode 0 before saturation

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_re  in  N_BINS*IN_W  real parts; bin k at [k*IN_W +: IN_W]
in_im  in  N_BINS*IN_W  imaginary parts, same packing
in_mode  in  1  0 = re^2+im^2, 1 = max(|re|,|im|) + (3*min)>>3
in_valid  in  1  input frame valid
in_ready  out  1  block can accept a frame
out_mag  out  N_BINS*MAG_W  magnitudes; bin k at [k*MAG_W +: MAG_W]
out_peak_idx  out  max(1,$clog2(N_BINS))  index of largest magnitude
out_peak_mag  out  MAG_W  largest magnitude
out_sat  out  1  at least one bin saturated this frame
out_valid  out  1  output frame valid
out_ready  in  1  downstream accepts the frame

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset values: in_ready=0, out_valid=0, out_mag=0, out_peak_idx=0, out_peak_mag=0, out_sat=0, FSM=IDLE, bin counter=0.
- in_ready is registered. It is 1 only in IDLE and rises on the first cycle after rst deasserts. It never depends combinationally on out_ready.
- FSM IDLE:
  - On in_valid && in_ready, latch in_re, in_im and in_mode.
  - Clear the peak, sat and out_mag registers, then go to RUN. in_ready drops in the same edge.
- FSM RUN:
  - Bin counter k runs 0..N_BINS-1 and issues one bin per cycle into stage 1.
  - Stage 1, mode 0: signed products re*re and im*im.
  - Stage 1, mode 1: unsigned abs values, max and min.
  - Stage 2, mode 0: sum (2*IN_W bits unsigned, no overflow), then >>SQ_SHIFT.
  - Stage 2, mode 1: max + ((3*min)>>3) at IN_W+1 bits.
  - Stage 2, both modes: saturate to 2^MAG_W-1 and set the sat flag if clipped. Write the result to slot k and update the peak.
  - Peak update uses strict greater-than, so on a tie the lowest index wins.
  - After the last bin leaves stage 2, go to DONE.
- FSM DONE:
  - out_valid=1, with all outputs stable.
  - On out_valid && out_ready, out_valid=0 and go to IDLE. in_ready=1 on the next cycle.
- Latency: out_valid rises exactly N_BINS+2 cycles after the accepting edge.
- Throughput: minimum frame period is N_BINS+4 cycles. Frames do not overlap.
- Inputs and in_mode changes while not in IDLE are ignored, because the latched copy is used.
- Abs of the most-negative input (-2^(IN_W-1)) is 2^(IN_W-1), exact in IN_W unsigned bits.
- out_mag is valid only while out_valid=1. Intermediate slot writes during RUN are allowed to be visible.
- Reset in any state aborts the frame: all outputs return to reset values and the partial frame is never presented.
- Reset asserted in the same cycle as in_valid: the frame is not accepted.

Test Plan:
1. Exact squared mode.
   - Stimulus: defaults, mode 0, bins (3,4),(0,0),(-5,12),(1,-1).
   - Required: out_mag = 25,0,169,2; peak_idx=2; peak_mag=169; sat=0; out_valid exactly 6 cycles after accept.
2. Saturation.
   - Stimulus: defaults, mode 0, bins (200,0),(256,0),(0,-1),(0,0).
   - Required: out_mag = 40000,65535,1,0; sat=1; peak_idx=1.
3. Approximate mode.
   - Stimulus: mode 1, bins (100,-40),(-32768,-32768),(0,0),(7,7).
   - Required: out_mag = 115,45056,0,9; peak_idx=1; sat=0.
4. Tie and backpressure.
   - Stimulus: all bins (0,7), mode 0.
   - Required: each magnitude 49, peak_idx=0.
   - Stimulus: hold out_ready=0 for 10 cycles with a second frame waiting on in_valid.
   - Required: outputs stable; in_ready=0; second frame accepted only on the cycle after the output handshake.
5. Reset mid-RUN.
   - Stimulus: assert rst for 1 cycle, 2 cycles after accept.
   - Required: out_valid never rises for that frame; all outputs 0; in_ready=1 the cycle after rst falls; next frame from test 1 gives the same results.
